// File: rtl/sample_window_framer_if.sv
// sample_window_framer_if
// Sample stream handshake between the sound-sample source and the framer.
//   sound_valid_i : source offers a sample this cycle
//   sound_ch_i    : channel index of the offered sample (CH_W bits)
//   sound_ready_o : framer accepts the sample (accept = valid & ready)
// modport master : sample source side
// modport slave  : framer side
interface sample_window_framer_if #(
  parameter int CH_W = 1
);
  logic            sound_valid_i;
  logic [CH_W-1:0] sound_ch_i;
  logic            sound_ready_o;

  modport master (output sound_valid_i, output sound_ch_i, input sound_ready_o);
  modport slave  (input sound_valid_i, input sound_ch_i, output sound_ready_o);
endinterface

// File: rtl/sample_window_framer.sv
// sample_window_framer
// Counts accepted multi-channel sample frames against a runtime-selected
// window length, pulses window_done_o on completion, then holds the CAR RAM
// clear strobe for CLEAR_CYCLES cycles (with back-pressure) before re-arming
// (continuous mode) or returning to idle (one-shot mode).
// Ports:
//   clk_i, rst_ni     : clock (rising edge), async active-low reset
//   enable_i          : arm/run; low aborts the current window
//   continuous_i      : 1 = re-arm after each window, 0 = one-shot
//   win_len_i         : window length in frames, 0 selects TOTAL_SAMPLES
//   snd               : sample handshake (slave side)
//   count_samples_o   : completed frames in the current window
//   ch_idx_o          : next expected channel
//   window_done_o     : one-cycle pulse per completed window
//   reset_car_rams_o  : CAR RAM clear strobe
//   seq_err_o         : sticky channel-order error
//   busy_o            : framer not idle
module sample_window_framer #(
  parameter int SAMPLING_RATE = 48,
  parameter int TIME_WINDOW   = 10,
  parameter int NUM_CH        = 1,
  parameter int CNT_W         = 16,
  parameter int CLEAR_CYCLES  = 4,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         continuous_i,
  input  logic [CNT_W-1:0]             win_len_i,
  sample_window_framer_if.slave        snd,
  output logic [CNT_W-1:0]             count_samples_o,
  output logic [CH_W-1:0]              ch_idx_o,
  output logic                         window_done_o,
  output logic                         reset_car_rams_o,
  output logic                         seq_err_o,
  output logic                         busy_o
);

  localparam longint TOTAL_SAMPLES = longint'(SAMPLING_RATE) * longint'(TIME_WINDOW);
  localparam longint CNT_MAX       = (longint'(1) << CNT_W) - longint'(1);
  localparam int     FL_W          = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);
  localparam logic [FL_W-1:0]  LAST_FL   = FL_W'(CLEAR_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_ONE    = FL_W'(1);

  if (TOTAL_SAMPLES > CNT_MAX) begin : g_bad_cnt_w
    $error("sample_window_framer: TOTAL_SAMPLES does not fit in CNT_W bits");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("sample_window_framer: NUM_CH must be at least 1");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("sample_window_framer: CLEAR_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, FLUSH = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CH_W-1:0]  ch_r, ch_s;
  logic [CNT_W-1:0] len_r, len_s;
  logic [FL_W-1:0]  flush_r, flush_s;
  logic             seq_err_r, seq_err_s;
  logic             aborted_r, aborted_s;
  logic             done_s;
  logic             ready_r, done_r, rams_r, busy_r;
  logic [CNT_W-1:0] latch_len_s;
  logic [CNT_W-1:0] count_inc_s;

  assign latch_len_s = (win_len_i == {CNT_W{1'b0}}) ? TOTAL_CNT : win_len_i;
  assign count_inc_s = count_r + CNT_ONE;

  // Next-state and next-counter logic for the IDLE/COUNT/FLUSH sequencer.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    ch_s      = ch_r;
    len_s     = len_r;
    flush_s   = flush_r;
    seq_err_s = seq_err_r;
    aborted_s = aborted_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_i) begin
          state_s   = COUNT;
          len_s     = latch_len_s;
          count_s   = {CNT_W{1'b0}};
          ch_s      = {CH_W{1'b0}};
          seq_err_s = 1'b0;
          aborted_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      COUNT: begin
        // An abort wins over a sample offered in the same cycle.
        if (!enable_i) begin
          state_s   = FLUSH;
          flush_s   = {FL_W{1'b0}};
          aborted_s = 1'b1;
        end else if (snd.sound_valid_i) begin
          if (snd.sound_ch_i != ch_r) begin
            seq_err_s = 1'b1;
          end else if (ch_r != LAST_CH) begin
            ch_s = ch_r + CH_ONE;
          end else begin
            ch_s    = {CH_W{1'b0}};
            count_s = count_inc_s;
            if (count_inc_s == len_r) begin
              state_s   = FLUSH;
              flush_s   = {FL_W{1'b0}};
              aborted_s = 1'b0;
              done_s    = 1'b1;
            end else begin
              state_s = COUNT;
            end
          end
        end else begin
          state_s = COUNT;
        end
      end
      FLUSH: begin
        // count_samples_o keeps the final count until the last clear cycle.
        if (flush_r == LAST_FL) begin
          count_s = {CNT_W{1'b0}};
          ch_s    = {CH_W{1'b0}};
          if (enable_i && continuous_i && !aborted_r) begin
            state_s = COUNT;
            len_s   = latch_len_s;
          end else begin
            state_s = IDLE;
          end
        end else begin
          flush_s = flush_r + FL_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      ch_r      <= {CH_W{1'b0}};
      len_r     <= {CNT_W{1'b0}};
      flush_r   <= {FL_W{1'b0}};
      seq_err_r <= 1'b0;
      aborted_r <= 1'b0;
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
      rams_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      ch_r      <= ch_s;
      len_r     <= len_s;
      flush_r   <= flush_s;
      seq_err_r <= seq_err_s;
      aborted_r <= aborted_s;
      ready_r   <= (state_s == COUNT);
      done_r    <= done_s;
      rams_r    <= (state_s == FLUSH);
      busy_r    <= (state_s != IDLE);
    end
  end

  assign snd.sound_ready_o = ready_r;
  assign count_samples_o   = count_r;
  assign ch_idx_o          = ch_r;
  assign window_done_o     = done_r;
  assign reset_car_rams_o  = rams_r;
  assign seq_err_o         = seq_err_r;
  assign busy_o            = busy_r;

endmodule

// File: tb/tb_sample_window_framer.sv
// tb_sample_window_framer
// Directed bench: one framer with NUM_CH=1 (most scenarios) and one with
// NUM_CH=2 (channel-order scenario), sharing clock and reset.
module tb_sample_window_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // single-channel instance
  logic        en1 = 1'b0, cont1 = 1'b0;
  logic [15:0] win1 = 16'd0;
  logic [15:0] cnt1;
  logic [0:0]  chi1;
  logic        done1, rams1, serr1, busy1;
  sample_window_framer_if #(.CH_W(1)) if1 ();

  // two-channel instance
  logic        en2 = 1'b0, cont2 = 1'b0;
  logic [15:0] win2 = 16'd0;
  logic [15:0] cnt2;
  logic [0:0]  chi2;
  logic        done2, rams2, serr2, busy2;
  sample_window_framer_if #(.CH_W(1)) if2 ();

  sample_window_framer #(.NUM_CH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en1), .continuous_i(cont1),
    .win_len_i(win1), .snd(if1.slave), .count_samples_o(cnt1), .ch_idx_o(chi1),
    .window_done_o(done1), .reset_car_rams_o(rams1), .seq_err_o(serr1), .busy_o(busy1)
  );

  sample_window_framer #(.NUM_CH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en2), .continuous_i(cont2),
    .win_len_i(win2), .snd(if2.slave), .count_samples_o(cnt2), .ch_idx_o(chi2),
    .window_done_o(done2), .reset_car_rams_o(rams2), .seq_err_o(serr2), .busy_o(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int which);
    logic b;
    int   k;
    k = 0;
    b = 1'b1;
    while (b && k < 20) begin
      tick();
      k++;
      b = (which == 1) ? busy1 : busy2;
    end
    n_cmp++;
    if (b !== 1'b0) begin n_fail++; $display("FAIL wait_idle dut%0d: busy=%0b after %0d cycles, want 0", which, b, k); end
  endtask

  task automatic test_reset();
    if1.sound_valid_i = 1'b0; if1.sound_ch_i = 1'b0;
    if2.sound_valid_i = 1'b0; if2.sound_ch_i = 1'b0;
    #12;
    n_cmp++; if (if1.sound_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", if1.sound_ready_o); end
    n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy1); end
    n_cmp++; if (rams1 !== 1'b0) begin n_fail++; $display("FAIL reset_rams: got %0b want 0", rams1); end
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done1); end
    n_cmp++; if (serr2 !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %0b want 0", serr2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    logic exp_end;
    en1 = 1'b1; cont1 = 1'b1; win1 = 16'd3;
    if1.sound_valid_i = 1'b1; if1.sound_ch_i = 1'b0;
    tick();
    n_cmp++; if (if1.sound_ready_o !== 1'b1) begin n_fail++; $display("FAIL cont_arm_ready: got %0b want 1", if1.sound_ready_o); end
    n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL cont_arm_count: got %0d want 0", cnt1); end
    for (int w = 0; w < 3; w++) begin
      for (int i = 1; i <= 3; i++) begin
        tick();
        exp_end = (i == 3) ? 1'b1 : 1'b0;
        n_cmp++; if (cnt1 !== 16'(i)) begin n_fail++; $display("FAIL cont_count w%0d i%0d: got %0d want %0d", w, i, cnt1, i); end
        n_cmp++; if (done1 !== exp_end) begin n_fail++; $display("FAIL cont_done w%0d i%0d: got %0b want %0b", w, i, done1, exp_end); end
        n_cmp++; if (rams1 !== exp_end) begin n_fail++; $display("FAIL cont_rams w%0d i%0d: got %0b want %0b", w, i, rams1, exp_end); end
        n_cmp++; if (if1.sound_ready_o !== ~exp_end) begin n_fail++; $display("FAIL cont_ready w%0d i%0d: got %0b want %0b", w, i, if1.sound_ready_o, ~exp_end); end
      end
      for (int f = 1; f <= 3; f++) begin
        tick();
        n_cmp++; if (rams1 !== 1'b1) begin n_fail++; $display("FAIL cont_flush_rams w%0d f%0d: got %0b want 1", w, f, rams1); end
        n_cmp++; if (if1.sound_ready_o !== 1'b0) begin n_fail++; $display("FAIL cont_flush_ready w%0d f%0d: got %0b want 0", w, f, if1.sound_ready_o); end
        n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL cont_flush_done w%0d f%0d: got %0b want 0", w, f, done1); end
        n_cmp++; if (cnt1 !== 16'd3) begin n_fail++; $display("FAIL cont_flush_count w%0d f%0d: got %0d want 3", w, f, cnt1); end
      end
      tick();
      n_cmp++; if (rams1 !== 1'b0) begin n_fail++; $display("FAIL cont_rearm_rams w%0d: got %0b want 0", w, rams1); end
      n_cmp++; if (if1.sound_ready_o !== 1'b1) begin n_fail++; $display("FAIL cont_rearm_ready w%0d: got %0b want 1", w, if1.sound_ready_o); end
      n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL cont_rearm_count w%0d: got %0d want 0", w, cnt1); end
    end
    en1 = 1'b0;
    wait_idle(1);
  endtask

  task automatic test_one_shot();
    en1 = 1'b1; cont1 = 1'b0; win1 = 16'd2;
    if1.sound_valid_i = 1'b1; if1.sound_ch_i = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL oneshot_done: got %0b want 1", done1); end
    n_cmp++; if (cnt1 !== 16'd2) begin n_fail++; $display("FAIL oneshot_count: got %0d want 2", cnt1); end
    en1 = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      tick();
      n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL oneshot_flush_busy f%0d: got %0b want 1", f, busy1); end
      n_cmp++; if (rams1 !== 1'b1) begin n_fail++; $display("FAIL oneshot_flush_rams f%0d: got %0b want 1", f, rams1); end
    end
    tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL oneshot_idle_busy: got %0b want 0", busy1); end
    n_cmp++; if (rams1 !== 1'b0) begin n_fail++; $display("FAIL oneshot_idle_rams: got %0b want 0", rams1); end
    n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL oneshot_idle_count: got %0d want 0", cnt1); end
    tick();
    n_cmp++; if (if1.sound_ready_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_idle_ready: got %0b want 0", if1.sound_ready_o); end
    en1 = 1'b1;
    tick();
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL oneshot_restart_busy: got %0b want 1", busy1); end
    n_cmp++; if (if1.sound_ready_o !== 1'b1) begin n_fail++; $display("FAIL oneshot_restart_ready: got %0b want 1", if1.sound_ready_o); end
    tick();
    n_cmp++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL oneshot_restart_count: got %0d want 1", cnt1); end
    en1 = 1'b0;
    wait_idle(1);
  endtask

  task automatic test_abort();
    en1 = 1'b1; cont1 = 1'b1; win1 = 16'd5;
    if1.sound_valid_i = 1'b1; if1.sound_ch_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL abort_pre_count: got %0d want 1", cnt1); end
    en1 = 1'b0;
    tick();
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b want 0", done1); end
    n_cmp++; if (rams1 !== 1'b1) begin n_fail++; $display("FAIL abort_rams: got %0b want 1", rams1); end
    n_cmp++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL abort_hold_count: got %0d want 1", cnt1); end
    // enable back high during the flush must not re-arm an aborted window
    en1 = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      tick();
      n_cmp++; if (rams1 !== 1'b1) begin n_fail++; $display("FAIL abort_flush_rams f%0d: got %0b want 1", f, rams1); end
    end
    tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy: got %0b want 0", busy1); end
    n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL abort_idle_count: got %0d want 0", cnt1); end
    en1 = 1'b0;
    tick();
  endtask

  task automatic test_default_window();
    int early;
    early = 0;
    en1 = 1'b1; cont1 = 1'b0; win1 = 16'd0;
    if1.sound_valid_i = 1'b1; if1.sound_ch_i = 1'b0;
    tick();
    for (int i = 0; i < 479; i++) begin
      tick();
      if (done1 === 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL default_early_done: got %0d pulses want 0", early); end
    n_cmp++; if (cnt1 !== 16'd479) begin n_fail++; $display("FAIL default_count479: got %0d want 479", cnt1); end
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL default_done: got %0b want 1", done1); end
    n_cmp++; if (cnt1 !== 16'd480) begin n_fail++; $display("FAIL default_count480: got %0d want 480", cnt1); end
    en1 = 1'b0;
    if1.sound_valid_i = 1'b0;
    wait_idle(1);
  endtask

  task automatic test_seq_err();
    logic [0:0]  ch_seq [5];
    logic [15:0] exp_cnt [5];
    logic [0:0]  exp_ch [5];
    logic        exp_err [5];
    logic        exp_done [5];
    ch_seq   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_cnt  = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    exp_ch   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_err  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    en2 = 1'b1; cont2 = 1'b0; win2 = 16'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      if2.sound_valid_i = 1'b1; if2.sound_ch_i = ch_seq[i];
      tick();
      n_cmp++; if (cnt2 !== exp_cnt[i]) begin n_fail++; $display("FAIL seq_count s%0d: got %0d want %0d", i, cnt2, exp_cnt[i]); end
      n_cmp++; if (chi2 !== exp_ch[i]) begin n_fail++; $display("FAIL seq_ch_idx s%0d: got %0d want %0d", i, chi2, exp_ch[i]); end
      n_cmp++; if (serr2 !== exp_err[i]) begin n_fail++; $display("FAIL seq_err s%0d: got %0b want %0b", i, serr2, exp_err[i]); end
      n_cmp++; if (done2 !== exp_done[i]) begin n_fail++; $display("FAIL seq_done s%0d: got %0b want %0b", i, done2, exp_done[i]); end
    end
    if2.sound_valid_i = 1'b0;
    en2 = 1'b0;
    wait_idle(2);
    n_cmp++; if (serr2 !== 1'b1) begin n_fail++; $display("FAIL seq_err_sticky: got %0b want 1", serr2); end
    en2 = 1'b1;
    tick();
    n_cmp++; if (serr2 !== 1'b0) begin n_fail++; $display("FAIL seq_err_clear: got %0b want 0", serr2); end
    en2 = 1'b0;
    wait_idle(2);
  endtask

  task automatic test_reset_flush();
    en1 = 1'b1; cont1 = 1'b1; win1 = 16'd1;
    if1.sound_valid_i = 1'b1; if1.sound_ch_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_len1_done: got %0b want 1", done1); end
    tick();
    n_cmp++; if (rams1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_flush2_rams: got %0b want 1", rams1); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rams1 !== 1'b0) begin n_fail++; $display("FAIL rstfl_rams: got %0b want 0", rams1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rstfl_busy: got %0b want 0", busy1); end
    n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL rstfl_count: got %0d want 0", cnt1); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_rearm_busy: got %0b want 1", busy1); end
    n_cmp++; if (if1.sound_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstfl_rearm_ready: got %0b want 1", if1.sound_ready_o); end
    tick();
    n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL rstfl_rearm_done: got %0b want 1", done1); end
    en1 = 1'b0;
    if1.sound_valid_i = 1'b0;
    wait_idle(1);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_one_shot();
    test_abort();
    test_default_window();
    test_seq_err();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_window_framer.md
# sample_window_framer

Parametrised sample-window sequencer in the front end of the audio pipeline, between the sound-sample source and the CAR filter-bank RAMs. It counts accepted multi-channel sample frames against a runtime-selectable window length and signals each completed window. It then holds the CAR RAM clear for a fixed number of cycles while applying back-pressure, and either re-arms automatically (continuous mode) or returns to idle (one-shot mode).

## Interface
- `SAMPLING_RATE`, 48: samples per ms; used only for the default window.
- `TIME_WINDOW`, 10: default window in ms; `TOTAL_SAMPLES = SAMPLING_RATE*TIME_WINDOW`.
- `NUM_CH`, 1: interleaved channels per frame, ≥1.
- `CNT_W`, 16: counter width; elaboration error if `TOTAL_SAMPLES > 2**CNT_W-1`.
- `CLEAR_CYCLES`, 4: cycles `reset_car_rams_o` is held, ≥1.
- `CH_W` (derived): `max(1, $clog2(NUM_CH))`.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: arm/run; low aborts the current window.
- `continuous_i` in 1: 1 = re-arm after each window; 0 = one-shot.
- `win_len_i` in CNT_W: window length in frames; 0 selects `TOTAL_SAMPLES`.
- `sound_valid_i` in 1: sample valid.
- `sound_ch_i` in CH_W: channel index of the offered sample.
- `sound_ready_o` out 1: sample accepted when valid & ready.
- `count_samples_o` out CNT_W: completed frames in the current window.
- `ch_idx_o` out CH_W: next expected channel.
- `window_done_o` out 1: one-cycle pulse per completed window.
- `reset_car_rams_o` out 1: CAR RAM clear strobe.
- `seq_err_o` out 1: sticky channel-order error.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States: IDLE, COUNT, FLUSH. All counters and outputs are registered.
- Reset: state IDLE; `count`=0, `ch_idx`=0, `L`=0, `seq_err`=0, and all outputs 0.
- IDLE: `sound_ready_o`=0. When `enable_i`=1, go to COUNT, latch `L` = (`win_len_i`==0 ? `TOTAL_SAMPLES` : `win_len_i`), clear `count`, `ch_idx` and `seq_err`.
- COUNT: `sound_ready_o`=1. On accept:
  - `sound_ch_i` ≠ `ch_idx`: set `seq_err`; drop the sample; counters unchanged.
  - Match, `ch_idx` < `NUM_CH`-1: `ch_idx`+1.
  - Match, `ch_idx` = `NUM_CH`-1: `ch_idx`←0, `count`+1. If `count`+1 == `L`, go to FLUSH and pulse `window_done_o`.
- COUNT with `enable_i`=0: abort to FLUSH. No `window_done_o`. Takes priority over a simultaneous accept, which is dropped.
- FLUSH: `sound_ready_o`=0, `reset_car_rams_o`=1 for exactly `CLEAR_CYCLES` cycles, `count_samples_o` holds its final value. On the last cycle, `count`←0 and `ch_idx`←0. Then:
  - `enable_i` & `continuous_i` & not aborted: go to COUNT and re-latch `L` from `win_len_i`.
  - Otherwise: go to IDLE.
- `win_len_i` changes take effect only at a latch point.
- `count` never exceeds `L`, so there is no wrap. `L`=1 ends the window on the first complete frame.
- `seq_err_o` stays set until the next IDLE→COUNT transition, or reset.
- Reset asserted mid-window or mid-flush forces reset values immediately. The flush is truncated and the window is not completed.

## Timing
- Window-completing accept at edge k: from k, state=FLUSH, `window_done_o`=1 for cycle k only, `reset_car_rams_o`=1 for cycles k…k+CLEAR_CYCLES-1.
- Continuous re-arm: `sound_ready_o`=1 again at edge k+CLEAR_CYCLES, giving a window gap of `CLEAR_CYCLES` cycles of back-pressure.
- IDLE→COUNT: `enable_i` sampled at edge k; `sound_ready_o`=1 from k.
- Throughput in COUNT: one sample per cycle.
- `count_samples_o` and `ch_idx_o` update at the edge of the accept.

## Test plan
- NUM_CH=1, `win_len_i`=3, continuous=1, valid held high: 3 accepts → `count_samples_o` 1,2,3. `window_done_o` is one pulse. `reset_car_rams_o` is high 4 cycles with ready=0. Count is then 0 and ready returns; repeats for 3 windows.
- `win_len_i`=0, NUM_CH=1: 479 samples give no done; the 480th sample produces the `window_done_o` pulse.
- NUM_CH=2, `win_len_i`=2: channels 0,1,1,0,1 → the third sample (ch 1) sets `seq_err_o` and is dropped. Done fires after the 5th sample (`count`=2).
- continuous=0, `win_len_i`=2: after the window and a 4-cycle flush, state is IDLE with `busy_o`=0. `enable_i` low→high starts a new window.
- `enable_i` dropped at `count`=1 of L=5: no done; 4-cycle flush; IDLE with count 0.
- `rst_ni` asserted during the 2nd flush cycle: `reset_car_rams_o`, `busy_o`, `count_samples_o` go to 0 asynchronously. Release with `enable_i`=1 → COUNT on the next edge.
